// File: rtl/mem_arbiter.sv
// Shares one fixed-latency single-ported memory between instruction fetch (I) and data (D).
// D has priority. Each grant holds the memory inputs for MEM_LAT cycles and then pulses a done.
module mem_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int MEM_LAT = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              hlt_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_data_o,
  output logic              if_done_o,
  output logic              if_stall_o,
  input  logic              d_req_i,
  input  logic              d_wr_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [DATA_W-1:0] d_wdata_i,
  output logic [DATA_W-1:0] d_rdata_o,
  output logic              d_done_o,
  output logic              d_stall_o,
  output logic              mem_en_o,
  output logic              mem_wr_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              busy_o
);

  localparam int CNT_W = $clog2(MEM_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LAT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              mem_en_q;
  logic              mem_wr_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [DATA_W-1:0] if_data_q;
  logic [DATA_W-1:0] d_rdata_q;
  logic              if_done_q;
  logic              d_done_q;

  // A port whose done is high this cycle still shows its old request, so it is skipped.
  logic d_elig;
  logic i_elig;
  assign d_elig = d_req_i & ~d_done_q;
  assign i_elig = if_req_i & ~if_done_q & ~hlt_i;

  // Arbitration, transaction sequencing and all registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      mem_en_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_data_q   <= '0;
      d_rdata_q   <= '0;
      if_done_q   <= 1'b0;
      d_done_q    <= 1'b0;
    end else begin
      if_done_q <= 1'b0;
      d_done_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (d_elig) begin
            state_q     <= BUSY_D;
            cnt_q       <= CNT_INIT;
            mem_en_q    <= 1'b1;
            mem_wr_q    <= d_wr_i;
            mem_addr_q  <= d_addr_i;
            mem_wdata_q <= d_wdata_i;
          end else if (i_elig) begin
            state_q    <= BUSY_I;
            cnt_q      <= CNT_INIT;
            mem_en_q   <= 1'b1;
            mem_wr_q   <= 1'b0;
            mem_addr_q <= if_addr_i;
          end else begin
            state_q  <= IDLE;
            mem_en_q <= 1'b0;
            mem_wr_q <= 1'b0;
          end
        end
        BUSY_I: begin
          if (cnt_q == '0) begin
            state_q   <= IDLE;
            mem_en_q  <= 1'b0;
            mem_wr_q  <= 1'b0;
            if_done_q <= 1'b1;
            if_data_q <= mem_rdata_i;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        BUSY_D: begin
          if (cnt_q == '0) begin
            state_q  <= IDLE;
            mem_en_q <= 1'b0;
            mem_wr_q <= 1'b0;
            d_done_q <= 1'b1;
            // A write completion leaves the last read data visible.
            if (!mem_wr_q) begin
              d_rdata_q <= mem_rdata_i;
            end else begin
              d_rdata_q <= d_rdata_q;
            end
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: begin
          state_q  <= IDLE;
          cnt_q    <= '0;
          mem_en_q <= 1'b0;
          mem_wr_q <= 1'b0;
        end
      endcase
    end
  end

  assign if_data_o   = if_data_q;
  assign if_done_o   = if_done_q;
  assign d_rdata_o   = d_rdata_q;
  assign d_done_o    = d_done_q;
  assign mem_en_o    = mem_en_q;
  assign mem_wr_o    = mem_wr_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign busy_o      = (state_q != IDLE);
  assign if_stall_o  = if_req_i & ~if_done_q;
  assign d_stall_o   = d_req_i & ~d_done_q;

endmodule
